// File: rtl/sdm_alloc_pkg.sv
// Shared types and default sizes for the SDM output-port VC allocator.
package sdm_alloc_pkg;

    localparam int unsigned SDM_DEF_N = 8;
    localparam int unsigned SDM_DEF_M = 2;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } vc_state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo N.
module rr_arb
    import sdm_alloc_pkg::*;
#(
    parameter  int unsigned N  = SDM_DEF_N,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic          vld_c
);

    int idx;

    // Scan upward from the pointer and keep the first hit.
    always_comb begin
        gnt_c = '0;
        vld_c = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!vld_c && req[idx]) begin
                gnt_c[idx] = 1'b1;
                vld_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdm_port_alloc.sv
// Output-port VC allocator: one FREE/BUSY FSM and owner per output VC,
// at most one new grant per cycle, round-robin over requesters.
module sdm_port_alloc
    import sdm_alloc_pkg::*;
#(
    parameter int unsigned N = SDM_DEF_N,
    parameter int unsigned M = SDM_DEF_M
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [M-1:0]   blk,
    output logic [N-1:0]   ack,
    output logic [M*N-1:0] cfg,
    output logic [M-1:0]   busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    vc_state_e       state_q [M];
    vc_state_e       state_d [M];
    logic [PW-1:0]   owner_q [M];
    logic [PW-1:0]   owner_d [M];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;

    logic [N-1:0]    elig_req;
    logic [M-1:0]    elig_vc;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [PW-1:0]   win;
    logic            grant;

    logic [N-1:0]    ack_d;
    logic [M*N-1:0]  cfg_d;
    logic [M-1:0]    busy_d;

    // Requesters not yet holding a VC; VCs free at this edge and not blocked.
    always_comb begin
        elig_req = req & ~ack;
        elig_vc  = '0;
        for (int m = 0; m < M; m++) begin
            elig_vc[m] = (state_q[m] == FREE) && !blk[m];
        end
    end

    rr_arb #(.N(N)) u_rr_arb (
        .req   (elig_req),
        .ptr   (ptr_q),
        .gnt_c (gnt),
        .vld_c (gnt_vld)
    );

    // One-hot winner to index.
    always_comb begin
        win = '0;
        for (int n = 0; n < N; n++) begin
            if (gnt[n]) win = PW'(n);
        end
    end

    // Next state: release dropped owners, then grant the lowest eligible VC.
    // Eligibility uses the pre-edge state, so a VC freed now is not regranted now.
    always_comb begin
        ptr_d = ptr_q;
        grant = 1'b0;
        for (int m = 0; m < M; m++) begin
            state_d[m] = state_q[m];
            owner_d[m] = owner_q[m];
        end
        for (int m = 0; m < M; m++) begin
            if (state_q[m] == BUSY && !req[owner_q[m]]) state_d[m] = FREE;
        end
        for (int m = 0; m < M; m++) begin
            if (!grant && gnt_vld && elig_vc[m]) begin
                state_d[m] = BUSY;
                owner_d[m] = win;
                grant      = 1'b1;
            end
        end
        if (grant) begin
            ptr_d = (32'(win) == (N - 1)) ? '0 : win + PW'(1);
        end
    end

    // Crossbar image of the next state, with ack/busy as its row/column ORs.
    always_comb begin
        ack_d  = '0;
        cfg_d  = '0;
        busy_d = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                if (state_d[m] == BUSY && owner_d[m] == PW'(n)) begin
                    cfg_d[m*N + n] = 1'b1;
                    ack_d[n]       = 1'b1;
                    busy_d[m]      = 1'b1;
                end
            end
        end
    end

    // State and registered outputs; reset drops every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < M; m++) begin
                state_q[m] <= FREE;
                owner_q[m] <= '0;
            end
            ptr_q <= '0;
            ack   <= '0;
            cfg   <= '0;
            busy  <= '0;
        end else begin
            for (int m = 0; m < M; m++) begin
                state_q[m] <= state_d[m];
                owner_q[m] <= owner_d[m];
            end
            ptr_q <= ptr_d;
            ack   <= ack_d;
            cfg   <= cfg_d;
            busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_sdm_port_alloc.sv
// Scoreboard bench for sdm_port_alloc: owner-list reference model, directed
// scenarios, then randomized req/blk traffic with structural and fairness checks.
module tb_sdm_port_alloc;

    localparam int N = 8;
    localparam int M = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [M-1:0]   blk = '0;
    logic [N-1:0]   ack;
    logic [M*N-1:0] cfg;
    logic [M-1:0]   busy;

    sdm_port_alloc #(.N(N), .M(M)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .blk  (blk),
        .ack  (ack),
        .cfg  (cfg),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        bit             rst;
        logic [N-1:0]   req;
        logic [M-1:0]   blk;
        logic [N-1:0]   ack;
        logic [M*N-1:0] cfg;
        logic [M-1:0]   busy;
    } exp_t;

    exp_t sbq[$];
    int   cyc_count = 0;
    int   total = 0;
    int   bad   = 0;

    // Reference model: own[m] = requester holding VC m, -1 when free.
    int own [M];
    int mptr;

    always @(posedge clk) cyc_count++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_count, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [M-1:0] bk);
        bit holds [N];
        bit free_pre [M];
        int win;
        int vc;
        if (r) begin
            for (int m = 0; m < M; m++) own[m] = -1;
            mptr = 0;
            return;
        end
        for (int n = 0; n < N; n++) holds[n] = 1'b0;
        for (int m = 0; m < M; m++) begin
            free_pre[m] = (own[m] < 0);
            if (own[m] >= 0) holds[own[m]] = 1'b1;
        end
        for (int m = 0; m < M; m++) begin
            if (own[m] >= 0 && !rq[own[m]]) own[m] = -1;
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && rq[(mptr + k) % N] && !holds[(mptr + k) % N]) win = (mptr + k) % N;
        end
        vc = -1;
        for (int m = 0; m < M; m++) begin
            if (vc < 0 && free_pre[m] && !bk[m]) vc = m;
        end
        if (win >= 0 && vc >= 0) begin
            own[vc] = win;
            mptr    = (win + 1) % N;
        end
    endtask

    // Apply one cycle of inputs, record the model's post-edge outputs, advance.
    task automatic step(input bit r, input logic [N-1:0] rq, input logic [M-1:0] bk);
        exp_t e;
        rst = r;
        req = rq;
        blk = bk;
        model_step(r, rq, bk);
        e.cyc  = cyc_count + 1;
        e.rst  = r;
        e.req  = rq;
        e.blk  = bk;
        e.ack  = '0;
        e.cfg  = '0;
        e.busy = '0;
        for (int m = 0; m < M; m++) begin
            if (own[m] >= 0) begin
                e.cfg[m*N + own[m]] = 1'b1;
                e.ack[own[m]]       = 1'b1;
                e.busy[m]           = 1'b1;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every completed edge against the queued expectation.
    exp_t           me;
    logic [N-1:0]   prev_ack  = '0;
    logic [M-1:0]   prev_busy = '0;
    int             wait_cnt [N];
    int             newg;
    int             rows;
    bit             ok;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc_count) begin
            me = sbq.pop_front();
            check("outputs", 32'({ack, cfg, busy}), 32'({me.ack, me.cfg, me.busy}));
            ok = 1'b1;
            for (int m = 0; m < M; m++) begin
                if ($countones(cfg[m*N +: N]) > 1) ok = 1'b0;
            end
            for (int n = 0; n < N; n++) begin
                rows = 0;
                for (int m = 0; m < M; m++) rows += int'(cfg[m*N + n]);
                if (rows > 1) ok = 1'b0;
            end
            check("onehot", 32'(ok), 32'(1));
            if (me.rst) begin
                for (int n = 0; n < N; n++) wait_cnt[n] = 0;
            end else begin
                check("blocked_grant", 32'(busy & ~prev_busy & me.blk), 32'(0));
                newg = $countones(ack & ~prev_ack);
                ok   = 1'b1;
                for (int n = 0; n < N; n++) begin
                    if (me.req[n] && !prev_ack[n] && !ack[n]) wait_cnt[n] += newg;
                    else wait_cnt[n] = 0;
                    if (wait_cnt[n] >= N) ok = 1'b0;
                end
                if (newg > 0) check("fairness", 32'(ok), 32'(1));
            end
            prev_ack  = ack;
            prev_busy = busy;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] rq;
    logic [M-1:0] bk;
    initial begin
        for (int n = 0; n < N; n++) wait_cnt[n] = 0;
        for (int m = 0; m < M; m++) own[m] = -1;
        mptr = 0;

        // Reset state and single request.
        step(1, '0, '0);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_cfg", 32'(cfg), 32'(0));
        step(0, 8'h01, '0);
        check("r31_ack", 32'(ack), 32'h01);
        check("r31_cfg0", 32'(cfg[7:0]), 32'h01);
        check("r31_busy", 32'(busy), 32'b01);

        // Two simultaneous requests, one grant per cycle, pointer wrap.
        step(1, '0, '0);
        step(0, 8'h81, '0);
        check("r32_ack_a", 32'(ack), 32'h01);
        step(0, 8'h81, '0);
        check("r32_ack_b", 32'(ack), 32'h81);
        check("r32_cfg1", 32'(cfg[15:8]), 32'h80);

        // All busy, release then regrant one edge later.
        step(1, '0, '0);
        step(0, 8'h01, '0);
        step(0, 8'h03, '0);
        check("r33_ack_full", 32'(ack), 32'h03);
        step(0, 8'h07, '0);
        check("r33_wait", 32'(ack), 32'h03);
        step(0, 8'h05, '0);
        check("r33_release", 32'(busy), 32'b01);
        step(0, 8'h05, '0);
        check("r33_regrant", 32'(cfg[15:8]), 32'h04);

        // Blocked VC skipped; blocking a busy VC does not free it.
        step(1, '0, '0);
        step(0, 8'h04, 2'b01);
        check("r34_cfg1", 32'(cfg[15:8]), 32'h04);
        step(0, 8'h04, 2'b11);
        check("r34_busy", 32'(busy), 32'b10);

        // Reset mid-packet drops grants; re-arbitration restarts at 0.
        step(1, '0, '0);
        step(0, 8'h03, '0);
        step(0, 8'h03, '0);
        step(1, 8'h03, '0);
        check("r35_rst_busy", 32'(busy), 32'(0));
        step(0, 8'h03, '0);
        check("r35_first", 32'(ack), 32'h01);
        step(0, 8'h03, '0);
        check("r35_second", 32'(ack), 32'h03);

        // Randomized traffic: packets hold req for several cycles.
        rq = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int n = 0; n < N; n++) begin
                if (rq[n]) begin
                    if ($urandom_range(7) == 0) rq[n] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[n] = 1'b1;
                end
            end
            for (int m = 0; m < M; m++) bk[m] = ($urandom_range(3) == 0);
            step(($urandom_range(999) == 0), rq, bk);
        end

        step(0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("drain", 32'(sbq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
